// File: rtl/expctrl_pkg.sv
// Shared types and default widths for the exposure sequencer.
package expctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE_RST,
    EXPOSE,
    HANDOFF,
    WAIT_RO,
    RO_ACK,
    DONE
  } state_t;

  localparam int C_RST_W_DEF    = 16;
  localparam int C_EXP_W_DEF    = 24;
  localparam int C_FCNT_W_DEF   = 16;
  localparam int C_ACK_HOLD_DEF = 2;
  localparam int C_TO_CYC_DEF   = 65535;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/expctrl_timer.sv
// Loadable down-counter with enable and zero flag; stops at zero.
module expctrl_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority; otherwise count down while enabled, holding at zero.
  always_ff @(posedge clk) begin
    if (!rst_n)                 cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/exposure_ctrl.sv
// Exposure sequencer: global pixel reset, DRAIN_B exposure window, then the
// FSMIND1/FSMIND0 handshake with the readout FSM. Optional handshake watchdog
// is enabled by defining EXPCTRL_TIMEOUT_EN.
module exposure_ctrl
  import expctrl_pkg::*;
#(
  parameter int C_RST_W    = C_RST_W_DEF,
  parameter int C_EXP_W    = C_EXP_W_DEF,
  parameter int C_FCNT_W   = C_FCNT_W_DEF,
  parameter int C_ACK_HOLD = C_ACK_HOLD_DEF,
  parameter int C_TO_CYC   = C_TO_CYC_DEF
) (
  input  logic                ADC_PIXCLK,
  input  logic                RESET_N,
  input  logic                START,
  input  logic                CONT,
  input  logic                ABORT,
  input  logic [C_RST_W-1:0]  T_RST,
  input  logic [C_EXP_W-1:0]  T_EXP,
  output logic                GPIXRES,
  output logic                DRAIN_B,
  output logic                FSMIND1,
  input  logic                FSMIND1ACK,
  input  logic                FSMIND0,
  output logic                FSMIND0ACK,
  output logic                BUSY,
  output logic                FRAME_DONE,
  output logic [C_FCNT_W-1:0] FRAME_CNT,
  output logic                ERR
);

  localparam int CW = imax(C_RST_W, C_EXP_W);

  state_t        state;
  logic [CW-1:0] t_exp_q;
  logic [CW-1:0] t_rst_in, t_exp_in;
  logic          launch, ro_done, wd_fire;
  logic          tmr_ld, tmr_en, tmr_zero;
  logic [CW-1:0] tmr_val;

  // T_RST is consumed by the timer on the launch edge, so only T_EXP needs a latch.
  assign t_rst_in = CW'(T_RST);
  assign t_exp_in = (T_EXP == '0) ? CW'(1) : CW'(T_EXP);
  assign launch   = (state == IDLE && START && FSMIND0) || (state == DONE && CONT);
  assign ro_done  = FSMIND0 && !FSMIND1ACK;

  // Duration timer control: counts PRE_RST, EXPOSE and the ack hold.
  always_comb begin
    tmr_ld  = 1'b0;
    tmr_en  = 1'b0;
    tmr_val = '0;
    case (state)
      IDLE, DONE: if (launch) begin
        tmr_ld  = 1'b1;
        tmr_val = (T_RST != '0) ? t_rst_in - 1'b1 : t_exp_in - 1'b1;
      end
      PRE_RST: if (tmr_zero) begin
        tmr_ld  = 1'b1;
        tmr_val = t_exp_q - 1'b1;
      end else begin
        tmr_en  = 1'b1;
      end
      EXPOSE, RO_ACK: tmr_en = 1'b1;
      WAIT_RO: if (ro_done) begin
        tmr_ld  = 1'b1;
        tmr_val = CW'(C_ACK_HOLD - 1);
      end
      default: ;
    endcase
  end

  expctrl_timer #(.W(CW)) u_tmr (
    .clk(ADC_PIXCLK), .rst_n(RESET_N), .load(tmr_ld), .en(tmr_en),
    .load_val(tmr_val), .zero(tmr_zero)
  );

`ifdef EXPCTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(C_TO_CYC + 1);
  logic wd_ld, wd_en, wd_zero;
  // Armed on entry to HANDOFF, runs continuously through WAIT_RO.
  assign wd_ld = (state == EXPOSE) && tmr_zero && !ABORT;
  assign wd_en = (state == HANDOFF) || (state == WAIT_RO);
  expctrl_timer #(.W(WD_W)) u_wd (
    .clk(ADC_PIXCLK), .rst_n(RESET_N), .load(wd_ld), .en(wd_en),
    .load_val(WD_W'(C_TO_CYC - 1)), .zero(wd_zero)
  );
  assign wd_fire = wd_en && wd_zero;
`else
  assign wd_fire = 1'b0;
  assign ERR     = 1'b0;
`endif

  // Sequencer FSM with registered outputs.
  always_ff @(posedge ADC_PIXCLK) begin
    if (!RESET_N) begin
      state      <= IDLE;
      GPIXRES    <= 1'b0;
      DRAIN_B    <= 1'b0;
      FSMIND1    <= 1'b0;
      FSMIND0ACK <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
      FRAME_CNT  <= '0;
      t_exp_q    <= '0;
`ifdef EXPCTRL_TIMEOUT_EN
      ERR        <= 1'b0;
`endif
    end else begin
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (launch) begin
            t_exp_q <= t_exp_in;
            BUSY    <= 1'b1;
            if (T_RST != '0) begin
              state   <= PRE_RST;
              GPIXRES <= 1'b1;
            end else begin
              state   <= EXPOSE;
              DRAIN_B <= 1'b1;
            end
          end else begin
            state <= IDLE;
            BUSY  <= 1'b0;
          end
        end
        PRE_RST: begin
          if (ABORT) begin
            state   <= IDLE;
            GPIXRES <= 1'b0;
            BUSY    <= 1'b0;
          end else if (tmr_zero) begin
            state   <= EXPOSE;
            GPIXRES <= 1'b0;
            DRAIN_B <= 1'b1;
          end
        end
        EXPOSE: begin
          if (ABORT) begin
            state   <= IDLE;
            DRAIN_B <= 1'b0;
            BUSY    <= 1'b0;
          end else if (tmr_zero) begin
            state   <= HANDOFF;
            DRAIN_B <= 1'b0;
            FSMIND1 <= 1'b1;
          end
        end
        HANDOFF, WAIT_RO: begin
          if (wd_fire) begin
            state      <= IDLE;
            FSMIND1    <= 1'b0;
            FSMIND0ACK <= 1'b0;
            BUSY       <= 1'b0;
`ifdef EXPCTRL_TIMEOUT_EN
            ERR        <= 1'b1;
`endif
          end else if (state == HANDOFF) begin
            // Drop the request as soon as readout claims it to avoid a double readout.
            if (FSMIND1ACK) begin
              state   <= WAIT_RO;
              FSMIND1 <= 1'b0;
            end
          end else if (ro_done) begin
            state      <= RO_ACK;
            FSMIND0ACK <= 1'b1;
            FRAME_DONE <= 1'b1;
            FRAME_CNT  <= FRAME_CNT + 1'b1;
          end
        end
        RO_ACK: begin
          if (tmr_zero) begin
            state      <= DONE;
            FSMIND0ACK <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exposure_ctrl.sv
// Directed-plus-random bench for exposure_ctrl; reference is a duration and
// frame-count model derived from the frame rules.
module tb_exposure_ctrl;
  localparam int RW = 8, EW = 10, FW = 2, AH = 2, TO = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, cont, abort_i, ack1, ro_idle;
  logic [RW-1:0] t_rst;
  logic [EW-1:0] t_exp;
  logic          gpixres, drain_b, ind1, ack0, busy, fdone, err;
  logic [FW-1:0] fcnt;

  int total = 0, bad = 0, frames = 0;

  exposure_ctrl #(.C_RST_W(RW), .C_EXP_W(EW), .C_FCNT_W(FW),
                  .C_ACK_HOLD(AH), .C_TO_CYC(TO)) dut (
    .ADC_PIXCLK(clk), .RESET_N(rst_n), .START(start), .CONT(cont),
    .ABORT(abort_i), .T_RST(t_rst), .T_EXP(t_exp), .GPIXRES(gpixres),
    .DRAIN_B(drain_b), .FSMIND1(ind1), .FSMIND1ACK(ack1), .FSMIND0(ro_idle),
    .FSMIND0ACK(ack0), .BUSY(busy), .FRAME_DONE(fdone), .FRAME_CNT(fcnt),
    .ERR(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Start from IDLE, then scramble the duration inputs to prove they were latched.
  task automatic launch(input int r, input int e);
    t_rst = RW'(r);
    t_exp = EW'(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    t_rst = RW'($urandom);
    t_exp = EW'($urandom);
  endtask

  // Measure the reset and exposure windows against the requested durations.
  task automatic expose_phase(input int r, input int e);
    int n;
    n = 0;
    while (gpixres === 1'b1 && n < 2000) begin tick(); n++; end
    chk("rst_len", n, r);
    chk("drain_rise", drain_b, 1);
    n = 0;
    while (drain_b === 1'b1 && n < 4000) begin tick(); n++; end
    chk("exp_len", n, (e == 0) ? 1 : e);
    chk("ind1_rise", ind1, 1);
  endtask

  // Readout BFM: claim after ack_dly, read for ro_len cycles, then report idle.
  task automatic handshake(input int ack_dly, input int ro_len, input bit abort_ro,
                           input bit c, input int nr, input int ne);
    for (int i = 0; i < ack_dly; i++) tick();
    chk("ind1_hold", ind1, 1);
    ack1 = 1'b1;
    ro_idle = 1'b0;
    tick();
    chk("ind1_drop", ind1, 0);
    tick();
    chk("ind1_stay_low", ind1, 0);
    ack1 = 1'b0;
    if (abort_ro) abort_i = 1'b1;
    for (int i = 0; i < ro_len; i++) tick();
    chk("no_early_done", {fdone, ack0}, 0);
    chk("busy_ro", busy, 1);
    abort_i = 1'b0;
    cont = c;
    t_rst = RW'(nr);
    t_exp = EW'(ne);
    ro_idle = 1'b1;
    tick();
    frames++;
    chk("fdone", fdone, 1);
    chk("ack0_rise", ack0, 1);
    chk("fcnt", fcnt, frames % 4);
    tick();
    chk("fdone_pulse", fdone, 0);
    chk("ack0_hold", ack0, 1);
    tick();
    chk("ack0_fall", ack0, 0);
    chk("busy_in_done", busy, 1);
    tick();
    if (c) begin
      t_rst = RW'($urandom);
      t_exp = EW'($urandom);
    end else begin
      chk("busy_idle", busy, 0);
    end
  endtask

  initial begin
    int r0, e0, r1, e1, r2, e2, n;
    rst_n = 1'b0; start = 1'b0; cont = 1'b0; abort_i = 1'b0;
    ack1 = 1'b0; ro_idle = 1'b1; t_rst = '0; t_exp = '0;
    tick(); tick();
    chk("reset_outs", {gpixres, drain_b, ind1, ack0, busy, fdone, err, fcnt}, 0);
    rst_n = 1'b1;
    tick();

    // Single frame 4/10 with ack after 3 cycles.
    launch(4, 10);
    chk("busy_start", busy, 1);
    expose_phase(4, 10);
    handshake(3, 5, 0, 0, 0, 0);

    // Zero durations: PRE_RST skipped, one-cycle exposure.
    launch(0, 0);
    chk("skip_rst", gpixres, 0);
    expose_phase(0, 0);
    handshake(0, 0, 0, 0, 0, 0);

    // START while readout not idle is ignored.
    ro_idle = 1'b0;
    start = 1'b1;
    tick(); tick(); tick();
    chk("start_ignored", busy, 0);
    start = 1'b0;
    ro_idle = 1'b1;
    tick();

    // Continuous mode: three back-to-back frames with long readout.
    r0 = $urandom_range(0, 12); e0 = $urandom_range(0, 12);
    r1 = $urandom_range(0, 12); e1 = $urandom_range(0, 12);
    r2 = $urandom_range(0, 12); e2 = $urandom_range(0, 12);
    launch(r0, e0);
    expose_phase(r0, e0);
    handshake(3, 500, 0, 1, r1, e1);
    expose_phase(r1, e1);
    handshake(2, 500, 0, 1, r2, e2);
    expose_phase(r2, e2);
    handshake(1, 500, 0, 0, 0, 0);
    cont = 1'b0;

    // Abort mid-EXPOSE.
    launch(3, 8);
    for (int i = 0; i < 4; i++) tick();
    chk("in_expose", drain_b, 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_exp", {busy, drain_b, gpixres, ind1, fdone}, 0);
    chk("abort_cnt", fcnt, frames % 4);
    tick();

    // Abort mid-PRE_RST.
    launch(6, 5);
    tick(); tick();
    chk("in_prerst", gpixres, 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_rst", {busy, drain_b, gpixres}, 0);
    tick();

    // Abort on the final exposure edge beats the handoff.
    launch(0, 3);
    tick(); tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_prio", {busy, ind1, drain_b}, 0);
    tick();

    // Abort during WAIT_RO is ignored.
    launch(2, 2);
    expose_phase(2, 2);
    handshake(1, 6, 1, 0, 0, 0);

    // Random frames; counter wraps at 2 bits.
    for (int k = 0; k < 5; k++) begin
      r0 = $urandom_range(0, 20);
      e0 = $urandom_range(0, 30);
      launch(r0, e0);
      expose_phase(r0, e0);
      handshake($urandom_range(0, 6), $urandom_range(0, 20), 1'($urandom_range(0, 1)), 0, 0, 0);
    end

    // Reset while in HANDOFF.
    launch(2, 3);
    expose_phase(2, 3);
    tick();
    rst_n = 1'b0;
    tick();
    chk("reset_handoff", {gpixres, drain_b, ind1, ack0, busy, fdone, err, fcnt}, 0);
    rst_n = 1'b1;
    frames = 0;
    tick();

`ifdef EXPCTRL_TIMEOUT_EN
    launch(1, 2);
    expose_phase(1, 2);
    n = 0;
    while (ind1 === 1'b1 && n < 200) begin tick(); n++; end
    chk("to_len", n, TO);
    chk("to_err", err, 1);
    chk("to_idle", {busy, ack0, fdone}, 0);
    chk("to_cnt", fcnt, 0);
    tick();
    launch(1, 1);
    expose_phase(1, 1);
    handshake(1, 2, 0, 0, 0, 0);
    chk("err_sticky", err, 1);
`else
    launch(1, 2);
    expose_phase(1, 2);
    n = 0;
    for (int i = 0; i < 3 * TO; i++) begin tick(); if (ind1 === 1'b1) n++; end
    chk("no_to_hold", n, 3 * TO);
    chk("no_to_err", err, 0);
    handshake(0, 3, 0, 0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
